// File: rtl/regfile_dump_pkg.sv
// Shared types and default sizing for the register-file dump streamer.
// The DUMP_CHECKSUM_EN macro adds the CSUM state used for the trailing XOR beat.
package regfile_dump_pkg;

  localparam int REG_W    = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    DONE
`ifdef DUMP_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

endpackage

// File: rtl/regfile_dump_hold_reg.sv
// N-bit hold register with load enable and asynchronous active-low clear;
// it keeps a beat's data stable while the sink applies backpressure.
module dump_hold_reg #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_dump.sv
// Walks the register-file read port and streams one valid/ready beat per register.
// Define DUMP_CHECKSUM_EN to append one XOR-of-all-registers beat after the last register.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int N     = REG_W,
  parameter int NREGS = NUM_REGS,
  parameter int AW    = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        r_state, r_state_next;
  logic [AW-1:0] r_idx, r_idx_next;
  logic [AW-1:0] r_out_addr;
  logic [N-1:0]  w_hold;
  logic          w_load;
  logic          w_accept;

  assign w_load   = (r_state == READ);
  assign w_accept = out_valid && out_ready;

  dump_hold_reg #(.N(N)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_d    (rd_data),
    .o_q    (w_hold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_out_addr <= '0;
    end else begin
      r_state <= r_state_next;
      r_idx   <= r_idx_next;
      if (r_state == READ) begin
        r_out_addr <= r_idx;
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [N-1:0] r_csum;

  // Running XOR restarts with every new dump so an aborted pass never leaks in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (abort || (r_state == IDLE && start)) begin
      r_csum <= '0;
    end else if (r_state == READ) begin
      r_csum <= r_csum ^ rd_data;
    end
  end
`endif

  always_comb begin
    r_state_next = r_state;
    r_idx_next   = r_idx;
    rd_addr      = r_idx;
    out_valid    = 1'b0;
    out_data     = w_hold;
    out_addr     = r_out_addr;
    out_last     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (r_state)
      IDLE: begin
        rd_addr = '0;
        if (start) begin
          r_state_next = READ;
          r_idx_next   = '0;
        end
      end
      READ: begin
        busy         = 1'b1;
        r_state_next = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
`ifndef DUMP_CHECKSUM_EN
        out_last  = (r_idx == LAST_IDX);
`endif
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
            r_state_next = CSUM;
`else
            r_state_next = DONE;
`endif
          end else begin
            r_idx_next   = r_idx + AW'(1);
            r_state_next = READ;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_data  = r_csum;
        out_addr  = '0;
        out_last  = 1'b1;
        if (w_accept) begin
          r_state_next = DONE;
        end
      end
`endif
      DONE: begin
        done         = 1'b1;
        r_state_next = IDLE;
        r_idx_next   = '0;
      end
      default: begin
        r_state_next = IDLE;
        r_idx_next   = '0;
      end
    endcase

    // Abort outranks everything, including a beat accepted this same cycle.
    if (abort) begin
      r_state_next = IDLE;
      r_idx_next   = '0;
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dumps, backpressure, ignored restarts,
// abort and asynchronous reset mid-dump, plus the checksum beat when enabled.
module tb_regfile_dump;

  localparam int N     = 16;
  localparam int NREGS = 8;
  localparam int AW    = 3;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NBEATS = NREGS + CS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [N-1:0] regs [0:NREGS-1];
  int n_checks;
  int n_errors;

  regfile_dump #(.N(N), .NREGS(NREGS), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete dump; optional 5-style stall on beat 3 and start re-pulses on beats 2..5.
  task automatic dump(input int stall_n, input bit restart);
    int t, beat, stall_left, stalled, done_seen;
    logic [N-1:0] csum;
    csum = '0;
    for (int i = 0; i < NREGS; i++) csum ^= regs[i];
    beat = 0; stall_left = 0; stalled = 0; done_seen = 0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; t = 1;
    check("first_read_busy", 32'(busy), 32'd1);
    check("first_read_valid", 32'(out_valid), 32'd0);
    check("first_read_addr", 32'(rd_addr), 32'd0);
    while (t < 80 && done_seen == 0) begin
      @(negedge clk); t++;
      start = restart && beat >= 2 && beat <= 5;
      if (stall_n > 0 && stalled == 0 && busy && !out_valid && rd_addr == 3) begin
        stalled = 1; stall_left = stall_n; out_ready = 1'b0;
      end
      if (out_valid && !out_ready) begin
        if (stall_left == 0) begin
          out_ready = 1'b1;
        end else begin
          check("stall_addr", 32'(out_addr), 32'd3);
          check("stall_data", 32'(out_data), 32'(regs[3]));
          stall_left--;
        end
      end
      if (out_valid && out_ready) begin
        if (beat < NREGS) begin
          check("beat_addr", 32'(out_addr), 32'(beat));
          check("beat_data", 32'(out_data), 32'(regs[beat]));
          check("beat_last", 32'(out_last), 32'((CS == 0) && (beat == NREGS - 1)));
        end else begin
          check("csum_addr", 32'(out_addr), 32'd0);
          check("csum_data", 32'(out_data), 32'(csum));
          check("csum_last", 32'(out_last), 32'd1);
        end
        beat++;
      end
      if (done) begin
        check("done_time", 32'(t), 32'(2 * NREGS + 1 + CS + stall_n));
        done_seen = 1;
      end
    end
    start = 1'b0;
    if (done_seen == 0) check("done_timeout", 32'd0, 32'd1);
    check("beat_count", 32'(beat), 32'(NBEATS));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("idle_no_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) regs[i] = 16'(i + 1);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_busy_done", 32'({busy, done, out_last}), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_without_start", 32'(busy), 32'd0);

    dump(0, 1'b0);
    dump(5, 1'b0);
    dump(0, 1'b1);

    begin : abort_test
      int guard;
      guard = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!(out_valid && out_addr == 4) && guard < 40) begin
        @(negedge clk); guard++;
      end
      check("abort_reach_beat4", 32'(guard < 40), 32'd1);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_rd_addr", 32'(rd_addr), 32'd0);
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_stays_idle", 32'(busy), 32'd0);
    end
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_beats_start", 32'(busy), 32'd0);
    dump(0, 1'b0);

    begin : reset_test
      int guard;
      guard = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!(busy && !out_valid && rd_addr == 2) && guard < 40) begin
        @(negedge clk); guard++;
      end
      check("reset_reach_read2", 32'(guard < 40), 32'd1);
      check("pre_reset_data", 32'(out_data), 32'(regs[1]));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_data", 32'(out_data), 32'd0);
      check("async_rst_addr", 32'(out_addr), 32'd0);
      check("async_rst_rd_addr", 32'(rd_addr), 32'd0);
      check("async_rst_flags", 32'({busy, out_valid, out_last, done}), 32'd0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 32'({busy, out_valid}), 32'd0);
    end
    dump(0, 1'b0);

`ifdef DUMP_CHECKSUM_EN
    regs[0] = 16'hA5A5; regs[1] = 16'h0F0F; regs[2] = 16'hFFFF; regs[3] = 16'h0000;
    regs[4] = 16'h1234; regs[5] = 16'h8001; regs[6] = 16'h00FF; regs[7] = 16'h5A5A;
    begin : csum_test
      int guard;
      logic [N-1:0] last_data;
      guard = 0; last_data = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!done && guard < 60) begin
        @(negedge clk); guard++;
        if (out_valid && out_last) last_data = out_data;
      end
      check("csum_finished", 32'(guard < 60), 32'd1);
      check("csum_hand_value", 32'(last_data), 32'h9DC5);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
